// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Shared types and sizing helpers for the SPI responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } spi_resp_state_t;

    localparam int DATA_W_DFLT = 16;
    localparam int BIT_CNT_W   = $clog2(DATA_W_DFLT + 2);

    // Counter must hold DATA_W+1 so an over-long frame stays distinguishable.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module : spi_sync_edge
// Brief  : SYNC_N-flop synchronizer plus history flop giving 1-clk edge strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter int   SYNC_N  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_N-1:0] r_chain;
    logic              r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_N{RST_VAL}};
            r_hist  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_N-2:0], d};
            r_hist  <= r_chain[SYNC_N-1];
        end
    end

    assign sync = r_chain[SYNC_N-1];
    assign rise = r_chain[SYNC_N-1] & ~r_hist;
    assign fall = ~r_chain[SYNC_N-1] & r_hist;

endmodule

`default_nettype wire

// File: rtl/spi_resp.sv
// ============================================================================
// Module : spi_resp
// Brief  : Oversampled 16-bit SPI responder; captures MOSI word, shifts out a
//          preloaded response on MISO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_resp
    import spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SYNC_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              wrt,
    output logic [DATA_W-1:0] rx_data,
    output logic              rdy,
    input  logic              clr_rdy,
    output logic              frm_err
);

    localparam int CNT_W = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DATA_W + 1);

    spi_resp_state_t   r_state;
    spi_resp_state_t   w_nxt_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift_rx;
    logic [DATA_W-1:0] r_shift_tx;
    logic [DATA_W-1:0] r_resp_buf;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rdy;
    logic              r_frm_err;
    logic              r_miso;

    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_sclk_sync_unused, w_sclk_rise, w_sclk_fall;
    logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;
    logic w_frame_start, w_frame_good, w_frame_bad;

    // SS_n resets low so a frame already in progress at reset is never joined.
    spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n),
        .sync(w_ss_sync), .rise(w_ss_rise), .fall(w_ss_fall)
    );

    spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK),
        .sync(w_sclk_sync_unused), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI),
        .sync(w_mosi_sync), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
    );

    assign w_frame_start = (r_state == ARMED) && w_ss_fall;
    assign w_frame_good  = (r_state == SHIFT) && w_ss_rise && (r_bit_cnt == c_cnt_full);
    assign w_frame_bad   = (r_state == SHIFT) && w_ss_rise && (r_bit_cnt != c_cnt_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE:    if (w_ss_sync) w_nxt_state = ARMED;
            ARMED:   if (w_ss_fall) w_nxt_state = SHIFT;
            SHIFT:   if (w_ss_rise) w_nxt_state = ARMED;
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift_rx <= '0;
            r_shift_tx <= '0;
            r_resp_buf <= '0;
            r_rx_data  <= '0;
            r_rdy      <= 1'b0;
            r_frm_err  <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_frm_err <= w_frame_bad;
            if (wrt) begin
                r_resp_buf <= tx_data;
            end
            if (w_frame_start) begin
                r_shift_tx <= wrt ? tx_data : r_resp_buf;
                r_bit_cnt  <= '0;
            end
            if (r_state == SHIFT) begin
                if (w_sclk_rise) begin
                    r_shift_rx <= {r_shift_rx[DATA_W-2:0], w_mosi_sync};
                    if (r_bit_cnt != c_cnt_max) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                // The master's first SCLK fall precedes any sampled bit.
                if (w_sclk_fall && (r_bit_cnt != '0)) begin
                    r_shift_tx <= {r_shift_tx[DATA_W-2:0], 1'b0};
                end
            end
            if (w_frame_good) begin
                r_rx_data <= r_shift_rx;
            end
            if (w_frame_good) begin
                r_rdy <= 1'b1;
            end else if (w_frame_start || clr_rdy) begin
                r_rdy <= 1'b0;
            end
            r_miso <= ((r_state == SHIFT) && (w_nxt_state == SHIFT)) ?
                      r_shift_tx[DATA_W-1] : 1'b0;
        end
    end

    assign MISO    = r_miso;
    assign rx_data = r_rx_data;
    assign rdy     = r_rdy;
    assign frm_err = r_frm_err;

endmodule

`default_nettype wire
